// File: rtl/conv_pkg.sv
// Shared widths, issuer state encoding and issue-beat layout for the conv datapath.
package conv_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned DATA_W  = 18;
  localparam int unsigned ADDR_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } issuer_state_e;

  // One beat on an issue stream; the allocator and filter issuer share this layout.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [DATA_W-1:0]  data;
  } issue_beat_t;

  localparam int unsigned BEAT_W = $bits(issue_beat_t);

endpackage

// File: rtl/issue_fifo2.sv
// Two-entry synchronous FIFO of issue beats; entry 0 is always the head.
module issue_fifo2
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  issue_beat_t push_data,
  output issue_beat_t head,
  output logic [1:0]  count
);

  issue_beat_t ent0_q, ent0_d;
  issue_beat_t ent1_q, ent1_d;
  logic [1:0]  count_q, count_d;

  // Apply pop (shift entry 1 forward) first, then place the push in the first free slot
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (pop && (count_q != 2'd0)) begin
      ent0_d  = ent1_q;
      count_d = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        ent0_d = push_data;
      end else begin
        ent1_d = push_data;
      end
      count_d = count_d + 2'd1;
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head  = ent0_q;
  assign count = count_q;

endmodule

// File: rtl/image_issuer.sv
// Raster-order scan of a W x H x D feature image into the issue_a stream.
module image_issuer
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] img_width,
  input  logic [COORD_W-1:0] img_height,
  input  logic [COORD_W-1:0] img_depth,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               issue_a_valid,
  output logic [COORD_W-1:0] issue_a_x,
  output logic [COORD_W-1:0] issue_a_y,
  output logic [COORD_W-1:0] issue_a_z,
  output logic [DATA_W-1:0]  issue_a_data,
  input  logic               issue_a_blocked,
  output logic               busy,
  output logic               done
);

  issuer_state_e      state_q, state_d;
  logic [COORD_W-1:0] width_q, width_d, height_q, height_d, depth_q, depth_d;
  logic [COORD_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, z_cnt_q, z_cnt_d;
  logic [ADDR_W-1:0]  addr_cnt_q, addr_cnt_d;
  logic               inflight_q, inflight_d;
  logic [COORD_W-1:0] fl_x_q, fl_x_d, fl_y_q, fl_y_d, fl_z_q, fl_z_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [1:0]         fifo_count;
  logic [2:0]         committed;
  logic               pop, x_last, y_last, z_last;
  issue_beat_t        push_beat, head_beat;

  // Credit check, read strobe, scan counters and state transitions
  always_comb begin
    pop       = (fifo_count != 2'd0) && !issue_a_blocked;
    // FIFO occupancy after this cycle's push (in-flight read) and pop
    committed = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    mem_rd_en = (state_q == RUN) && (committed < 3'd2);
    x_last    = (x_cnt_q == width_q  - COORD_W'(1));
    y_last    = (y_cnt_q == height_q - COORD_W'(1));
    z_last    = (z_cnt_q == depth_q  - COORD_W'(1));

    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    depth_d    = depth_q;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    z_cnt_d    = z_cnt_q;
    addr_cnt_d = addr_cnt_q;
    inflight_d = mem_rd_en;
    fl_x_d     = fl_x_q;
    fl_y_d     = fl_y_q;
    fl_z_d     = fl_z_q;
    if (mem_rd_en) begin
      fl_x_d = x_cnt_q;
      fl_y_d = y_cnt_q;
      fl_z_d = z_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          width_d    = img_width;
          height_d   = img_height;
          depth_d    = img_depth;
          x_cnt_d    = '0;
          y_cnt_d    = '0;
          z_cnt_d    = '0;
          addr_cnt_d = '0;
          if ((img_width == '0) || (img_height == '0) || (img_depth == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (mem_rd_en) begin
          // Counters stop on the last element so addr_cnt never passes W*H*D-1
          if (x_last && y_last && z_last) begin
            state_d = DRAIN;
          end else begin
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
            if (!x_last) begin
              x_cnt_d = x_cnt_q + COORD_W'(1);
            end else begin
              x_cnt_d = '0;
              if (!y_last) begin
                y_cnt_d = y_cnt_q + COORD_W'(1);
              end else begin
                y_cnt_d = '0;
                z_cnt_d = z_cnt_q + COORD_W'(1);
              end
            end
          end
        end
      end
      DRAIN: begin
        if (committed == 3'd0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);

    push_beat.x    = fl_x_q;
    push_beat.y    = fl_y_q;
    push_beat.z    = fl_z_q;
    push_beat.data = mem_rd_data;
  end

  // Scan state, latched dimensions, in-flight read tag and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      depth_q    <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      z_cnt_q    <= '0;
      addr_cnt_q <= '0;
      inflight_q <= 1'b0;
      fl_x_q     <= '0;
      fl_y_q     <= '0;
      fl_z_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      depth_q    <= depth_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      z_cnt_q    <= z_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      inflight_q <= inflight_d;
      fl_x_q     <= fl_x_d;
      fl_y_q     <= fl_y_d;
      fl_z_q     <= fl_z_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  issue_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .pop       (pop),
    .push_data (push_beat),
    .head      (head_beat),
    .count     (fifo_count)
  );

  assign mem_rd_addr   = addr_cnt_q;
  assign issue_a_valid = (fifo_count != 2'd0);
  assign issue_a_x     = head_beat.x;
  assign issue_a_y     = head_beat.y;
  assign issue_a_z     = head_beat.z;
  assign issue_a_data  = head_beat.data;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_image_issuer.sv
// Self-checking bench for image_issuer against a raster-order beat list and a RAM model.
module tb_image_issuer;
  import conv_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COORD_W-1:0] img_width, img_height, img_depth;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [DATA_W-1:0]  mem_rd_data;
  logic               issue_a_valid;
  logic [COORD_W-1:0] issue_a_x, issue_a_y, issue_a_z;
  logic [DATA_W-1:0]  issue_a_data;
  logic               issue_a_blocked;
  logic               busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] cur_beat, prev_beat;
  int unsigned       exp_addr;
  int unsigned       n_pop;
  int unsigned       seed = 0;
  int                block_mode = 0;
  bit                mon_en = 1'b0;
  bit                last_seen, prev_blk, hold_used;

  always #5 clk = ~clk;

  image_issuer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .img_width       (img_width),
    .img_height      (img_height),
    .img_depth       (img_depth),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .issue_a_valid   (issue_a_valid),
    .issue_a_x       (issue_a_x),
    .issue_a_y       (issue_a_y),
    .issue_a_z       (issue_a_z),
    .issue_a_data    (issue_a_data),
    .issue_a_blocked (issue_a_blocked),
    .busy            (busy),
    .done            (done)
  );

  assign cur_beat = {issue_a_x, issue_a_y, issue_a_z, issue_a_data};

  function automatic logic [DATA_W-1:0] ram_word(input int unsigned a);
    return DATA_W'(a * 10 + seed);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Synchronous feature RAM: one-cycle read latency
  always_ff @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram_word(int'(mem_rd_addr));
  end

  // Backpressure driver: none, a 3-cycle hold on beat (1,1), or random
  int hold_left = 0;
  initial begin
    issue_a_blocked = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (block_mode == 1) begin
        if (!hold_used && issue_a_valid && issue_a_x == 1 && issue_a_y == 1) begin
          hold_used = 1'b1;
          hold_left = 3;
        end
        issue_a_blocked = (hold_left > 0);
        if (hold_left > 0) hold_left--;
      end else if (block_mode == 2) begin
        issue_a_blocked = ($urandom_range(0, 2) == 0);
      end else begin
        issue_a_blocked = 1'b0;
      end
    end
  end

  // Stream monitor: transfers, read addresses, hold stability, done after the last beat
  initial begin
    logic [BEAT_W-1:0] eb;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_blk) begin
          check_eq("hold_valid", issue_a_valid, 1'b1);
          check_eq("hold_beat", cur_beat, prev_beat);
        end
        if (last_seen) begin
          check_eq("done_after_last", done, 1'b1);
          last_seen = 1'b0;
        end
        if (mem_rd_en) begin
          check_eq("rd_addr", mem_rd_addr, exp_addr);
          exp_addr++;
        end
        if (block_mode == 1 && issue_a_blocked && issue_a_valid)
          check_eq("rd_stall", mem_rd_en, 1'b0);
        if (issue_a_valid && !issue_a_blocked) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_beat", issue_a_valid, 1'b0);
          end else begin
            eb = exp_q.pop_front();
            check_eq("beat", cur_beat, eb);
            n_pop++;
            if (exp_q.size() == 0) last_seen = 1'b1;
          end
        end
        prev_blk  = issue_a_valid && issue_a_blocked;
        prev_beat = cur_beat;
      end
    end
  end

  task automatic start_scan(input int unsigned w, input int unsigned h, input int unsigned d);
    exp_q.delete();
    for (int unsigned z = 0; z < d; z++)
      for (int unsigned y = 0; y < h; y++)
        for (int unsigned x = 0; x < w; x++)
          exp_q.push_back({COORD_W'(x), COORD_W'(y), COORD_W'(z), ram_word(z * w * h + y * w + x)});
    exp_addr  = 0;
    n_pop     = 0;
    last_seen = 1'b0;
    prev_blk  = 1'b0;
    hold_used = 1'b0;
    mon_en    = 1'b1;
    @(negedge clk);
    img_width  = COORD_W'(w);
    img_height = COORD_W'(h);
    img_depth  = COORD_W'(d);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input int unsigned w, input int unsigned h, input int unsigned d,
                          input int mode, input bit poke);
    int          k;
    int          first_v;
    int unsigned n;
    int          budget;
    n          = w * h * d;
    block_mode = mode;
    first_v    = -1;
    start_scan(w, h, d);
    if (n > 0) check_eq("busy_rise", busy, 1'b1);
    k      = 0;
    budget = int'(n) * 8 + 20;
    while (!done && k < budget) begin
      if (issue_a_valid && first_v < 0) first_v = k;
      if (poke && k == 4) begin
        img_width  = 8'd2;
        img_height = 8'd2;
        img_depth  = 8'd2;
        start      = 1'b1;
      end
      if (poke && k == 5) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k >= budget) begin
      check_eq("done_timeout", done, 1'b1);
    end else begin
      if (mode == 0) check_eq("done_latency", k, (n == 0) ? 0 : n + 2);
      if (mode == 1) check_eq("done_latency_blk", k, n + 5);
      if (mode == 0 && n > 0) check_eq("first_valid", first_v, 2);
      check_eq("busy_at_done", busy, 1'b0);
    end
    @(negedge clk);
    check_eq("done_pulse", done, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
    check_eq("beats_left", exp_q.size(), 0);
    check_eq("reads", exp_addr, n);
    mon_en     = 1'b0;
    block_mode = 0;
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    start      = 1'b0;
    img_width  = '0;
    img_height = '0;
    img_depth  = '0;
    @(negedge clk);
    check_eq("rst_valid", issue_a_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rd_en", mem_rd_en, 1'b0);
    check_eq("rst_addr", mem_rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_scan(3, 3, 1, 0, 1'b0);
    run_scan(3, 3, 1, 1, 1'b0);
    run_scan(2, 2, 2, 0, 1'b0);
    run_scan(0, 5, 5, 0, 1'b0);

    // Reset in the middle of a 3x3x1 scan, then a clean rescan
    block_mode = 0;
    start_scan(3, 3, 1);
    k = 0;
    while (n_pop < 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("reach_beat5", n_pop, 5);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", issue_a_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_rd_en", mem_rd_en, 1'b0);
    check_eq("mid_rst_addr", mem_rd_addr, 0);
    check_eq("mid_rst_xyz", {issue_a_x, issue_a_y, issue_a_z}, 0);
    check_eq("mid_rst_data", issue_a_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan(3, 3, 1, 0, 1'b0);

    // Second start with different dimensions during a scan must be ignored
    run_scan(3, 3, 1, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      seed = $urandom_range(0, 1000);
      run_scan($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3), 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_issuer.md
Name: image_issuer

Overview:
- Producer side of the allocator's issue_a stream.
- Scans a W x H x D image held in on-chip feature RAM in raster order: x fastest, then y, then z.
- Reads each element through a 1-cycle-latency synchronous RAM port and presents (x, y, z, data) to the allocator.
- Honours the allocator's blocked backpressure with no lost or duplicated beats.

Parameters:
- COORD_W, 8, width of x/y/z coordinates and of the dimension inputs.
- DATA_W, 18, element data width.
- ADDR_W, 24, flat RAM address width; holds 255*255*255 - 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a scan; sampled only in IDLE.
- img_width  in  COORD_W  W, element count in x (0..255).
- img_height  in  COORD_W  H, element count in y.
- img_depth  in  COORD_W  D, element count in z.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  ADDR_W  flat address, z*W*H + y*W + x.
- mem_rd_data  in  DATA_W  RAM data, valid the cycle after mem_rd_en.
- issue_a_valid  out  1  beat present.
- issue_a_x  out  COORD_W  x coordinate of the presented beat.
- issue_a_y  out  COORD_W  y coordinate of the presented beat.
- issue_a_z  out  COORD_W  z coordinate of the presented beat.
- issue_a_data  out  DATA_W  data of the presented beat.
- issue_a_blocked  in  1  allocator cannot accept; a beat transfers when valid && !blocked.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final beat transfers.

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - state = IDLE.
  - All outputs 0: valid, busy, done, mem_rd_en, coordinates, data, address.
  - Output buffer emptied; any in-flight RAM read is discarded.
- States:
  - IDLE: on start, latch W/H/D, clear scan counters, go to RUN. If any dimension is 0, go directly to DONE instead.
  - RUN: issue reads while credits allow. After the read of the last element (x=W-1, y=H-1, z=D-1), go to DRAIN.
  - DRAIN: no further reads. When the buffer is empty and no read is in flight, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Dimensions are latched at start. Changes to img_* during a scan are ignored.
- start is ignored while busy.
- Scan counters are registered: x_cnt, y_cnt, z_cnt, addr_cnt.
  - The address is incremented by 1 per read; no multiplier.
  - x wraps W-1 -> 0 and increments y.
  - y wraps H-1 -> 0 and increments z.
- Output buffer:
  - 2-entry FIFO of {x, y, z, data}, COORD_W*3 + DATA_W bits.
  - Each read pushes its coordinates into a 1-deep in-flight register; the entry is written to the FIFO with mem_rd_data on the next cycle.
  - Credit rule: mem_rd_en = RUN && (fifo_count + inflight - pop) < 2, where pop = valid && !blocked in the current cycle. This guarantees no overflow.
  - issue_a_* is driven from the FIFO head, registered.
  - While blocked, the head and valid hold stable.
  - Simultaneous push and pop in the same cycle is legal; the count is unchanged.
- Latency and throughput:
  - The start edge is followed by mem_rd_en in the next cycle, addr 0.
  - issue_a_valid for beat 0 rises 2 cycles after the start edge.
  - With blocked held low, one beat transfers per cycle; N elements take N consecutive valid cycles.
  - done rises in the cycle after the last transfer.
- Coordinates are zero-extended into issue_a_*; issue_a_z is a real output (the allocator ignores z today).
- Maximum image 255x255x255; addr_cnt never exceeds 16,581,374.

Decomposition:
- Shared package (conv_pkg):
  - COORD_W, DATA_W, ADDR_W.
  - State encoding localparams: IDLE, RUN, DRAIN, DONE.
  - Issue-beat field layout, reused by the allocator and by a future filter issuer.
- One natural sub-module: issue_fifo2, a 2-entry synchronous FIFO with count, push/pop, and async reset.

Test Plan:
- W=3, H=3, D=1, RAM model data = addr*10, blocked=0, start at t0 -> 9 consecutive beats (0,0,0,0), (1,0,0,10), ... (2,2,0,80); first valid at t0+2; done pulse at t0+11; busy low afterwards.
- Same image, blocked=1 for 3 cycles while beat (1,1,0,40) is presented -> x/y/data/valid stable for all 3 cycles; mem_rd_en low once the FIFO is full; sequence resumes with no gap or duplicate; total 9 beats.
- W=2, H=2, D=2 -> beats 4..7 carry z=1, data 40..70; addresses 0..7 each read exactly once.
- W=0, H=5, D=5 -> no mem_rd_en and no valid; done 1 cycle after the start edge.
- Assert rst at beat 5 of a 3x3x1 scan, then start again after release -> all outputs 0 immediately; the new scan begins at (0,0,0,0) with no stale beat.
- start pulsed again mid-scan with different dimensions -> ignored; the original 9-beat sequence completes unchanged.
